// File: rtl/iir_decimator.sv
// iir_decimator: power-of-two sample decimator feeding a valid/ready output FIFO.
// Define IIR_DECIM_AVG_EN to output the rounded block mean instead of the last sample.
module iir_decimator #(
    parameter int MAXLOG2 = 6,
    parameter int DEPTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(MAXLOG2+1)-1:0] decim_log2,
    input  logic                         dv_in,
    input  logic signed [17:0]           d_in,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [17:0]           m_data,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         ovf,
    input  logic                         ovf_clr
);
    localparam int KW = $clog2(MAXLOG2+1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int NW = MAXLOG2 + 1;
    localparam logic [KW-1:0] KMAX = KW'(MAXLOG2);

    logic [MAXLOG2-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]       k_q, k_d;
    logic [KW-1:0]       k_in, k_eff;
    logic [NW-1:0]       one_sh;
    logic [MAXLOG2-1:0]  last_idx;
    logic                blk_end;
    logic                push_q, push_d;
    logic signed [17:0]  smp_q, smp_d;
    logic signed [17:0]  blk_val;

    logic signed [17:0]  mem [DEPTH];
    logic [PW-1:0]       rd_q, rd_d, wr_q, wr_d;
    logic                full, pop, push_ok, drop;
    logic                m_valid_q, m_valid_d;
    logic signed [17:0]  m_data_q, m_data_d;
    logic                ovf_q, ovf_d;

    // The exponent in force for this strobe: a block start uses the live input.
    assign k_in     = (decim_log2 > KMAX) ? KMAX : decim_log2;
    assign k_eff    = (cnt_q == '0) ? k_in : k_q;
    assign one_sh   = NW'(1) << k_eff;
    assign last_idx = one_sh[MAXLOG2-1:0] - 1'b1;
    assign blk_end  = dv_in && (cnt_q == last_idx);

    always_comb begin
        cnt_d  = cnt_q;
        k_d    = k_q;
        push_d = blk_end;
        smp_d  = smp_q;
        if (dv_in) begin
            cnt_d = blk_end ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) k_d = k_in;
        end
        if (blk_end) smp_d = blk_val;
    end

`ifdef IIR_DECIM_AVG_EN
    localparam int SW = 18 + MAXLOG2 + 1;
    localparam logic signed [SW-1:0] PMAX = SW'(131071);
    localparam logic signed [SW-1:0] NMIN = SW'(-131072);

    logic signed [SW-2:0] acc_q, acc_d;
    logic signed [SW-1:0] base, sum, rnd, rsum, shr;

    always_comb begin
        base = (cnt_q == '0) ? '0 : SW'(acc_q);
        sum  = base + SW'(d_in);
        rnd  = '0;
        if (k_eff != '0) rnd = SW'(1) << (k_eff - 1'b1);
        rsum = sum + rnd;
        shr  = rsum >>> k_eff;
        if (shr > PMAX)      blk_val = 18'sh1FFFF;
        else if (shr < NMIN) blk_val = -18'sh20000;
        else                 blk_val = shr[17:0];
        acc_d = dv_in ? sum[SW-2:0] : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`else
    assign blk_val = d_in;
`endif

    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = m_valid_q && m_ready;
    assign push_ok = push_q && (!full || pop);
    assign drop    = push_q && !push_ok;

    // Output register always mirrors the head entry after this cycle's updates.
    always_comb begin
        rd_d      = rd_q + PW'(pop);
        wr_d      = wr_q + PW'(push_ok);
        m_valid_d = (wr_d != rd_d);
        m_data_d  = m_data_q;
        if (m_valid_d) begin
            if (push_ok && (rd_d == wr_q)) m_data_d = smp_q;
            else                           m_data_d = mem[rd_d[AW-1:0]];
        end
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_q[AW-1:0]] <= smp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            k_q       <= '0;
            push_q    <= 1'b0;
            smp_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            k_q       <= k_d;
            push_q    <= push_d;
            smp_q     <= smp_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign level   = wr_q - rd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_iir_decimator.sv
// tb_iir_decimator: directed vectors and corner-case sequences for iir_decimator.
// Expected values follow IIR_DECIM_AVG_EN when it is defined.
module tb_iir_decimator;
    typedef struct {
        logic dv;
        int   d;
        bit   ev;
        int   ed;
        int   el;
    } vec_t;

`ifdef IIR_DECIM_AVG_EN
    localparam int P1 = 25;
    localparam int P2 = 65;
    localparam int KC0 = 2;
    localparam int KC1 = 7;
    localparam int RS = 9;
`else
    localparam int P1 = 40;
    localparam int P2 = 80;
    localparam int KC0 = 2;
    localparam int KC1 = 10;
    localparam int RS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] decim_log2 = '0;
    logic dv_in = 1'b0;
    logic signed [17:0] d_in = '0;
    logic m_valid;
    logic m_ready = 1'b0;
    logic signed [17:0] m_data;
    logic [4:0] level;
    logic ovf;
    logic ovf_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int cap[$];
    bit cap_en = 1'b0;

    iir_decimator #(.MAXLOG2(6), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .decim_log2(decim_log2),
        .dv_in(dv_in), .d_in(d_in), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .level(level),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (cap_en && m_valid && m_ready) cap.push_back(int'(m_data));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        d_in = 18'(v);
        dv_in = 1'b1;
        tick();
        dv_in = 1'b0;
    endtask

    function automatic int capv(input int i);
        return (cap.size() > i) ? cap[i] : -999999;
    endfunction

    initial begin
        vec_t tv[10];
        tv[0] = '{1'b1, 10, 1'b0, 0,  0};
        tv[1] = '{1'b1, 20, 1'b0, 0,  0};
        tv[2] = '{1'b1, 30, 1'b0, 0,  0};
        tv[3] = '{1'b1, 40, 1'b0, 0,  0};
        tv[4] = '{1'b1, 50, 1'b1, P1, 1};
        tv[5] = '{1'b1, 60, 1'b0, P1, 0};
        tv[6] = '{1'b1, 70, 1'b0, P1, 0};
        tv[7] = '{1'b1, 80, 1'b0, P1, 0};
        tv[8] = '{1'b0, 0,  1'b1, P2, 1};
        tv[9] = '{1'b0, 0,  1'b0, P2, 0};

        tick();
        tick();
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_data", int'(m_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        tick();

        decim_log2 = 3'd2;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dv_in = tv[i].dv;
            d_in = 18'(tv[i].d);
            tick();
            chk($sformatf("vec%0d_valid", i), int'(m_valid), int'(tv[i].ev));
            chk($sformatf("vec%0d_data", i), int'(m_data), tv[i].ed);
            chk($sformatf("vec%0d_level", i), int'(level), tv[i].el);
        end
        dv_in = 1'b0;

        decim_log2 = 3'd0;
        m_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(i);
        tick();
        tick();
        chk("fill_level", int'(level), 16);
        chk("fill_ovf", int'(ovf), 1);
        chk("fill_valid", int'(m_valid), 1);
        chk("fill_head", int'(m_data), 0);

        send(99);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_vs_drop_ovf", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr_ovf", int'(ovf), 0);
        chk("clr_level", int'(level), 16);

        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), int'(m_valid), 1);
            chk($sformatf("drain%0d_data", i), int'(m_data), i);
            tick();
        end
        chk("drain_empty_valid", int'(m_valid), 0);
        chk("drain_empty_level", int'(level), 0);

        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(100 + i);
        tick();
        tick();
        chk("full_level", int'(level), 16);
        send(200);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("pushpop_level", int'(level), 16);
        chk("pushpop_ovf", int'(ovf), 0);
        chk("pushpop_head", int'(m_data), 101);
        cap.delete();
        cap_en = 1'b1;
        m_ready = 1'b1;
        repeat (20) tick();
        cap_en = 1'b0;
        chk("pushpop_count", cap.size(), 16);
        chk("pushpop_first", capv(0), 101);
        chk("pushpop_last", capv(15), 200);

        cap.delete();
        cap_en = 1'b1;
        decim_log2 = 3'd1;
        send(1);
        decim_log2 = 3'd3;
        for (int i = 2; i <= 10; i++) send(i);
        repeat (4) tick();
        cap_en = 1'b0;
        chk("kchg_count", cap.size(), 2);
        chk("kchg_blk0", capv(0), KC0);
        chk("kchg_blk1", capv(1), KC1);

`ifdef IIR_DECIM_AVG_EN
        cap.delete();
        cap_en = 1'b1;
        decim_log2 = 3'd2;
        for (int i = 1; i <= 4; i++) send(i);
        for (int i = 1; i <= 4; i++) send(-i);
        repeat (4) send(131071);
        repeat (4) send(-131072);
        repeat (4) tick();
        cap_en = 1'b0;
        chk("avg_count", cap.size(), 4);
        chk("avg_pos", capv(0), 3);
        chk("avg_neg", capv(1), -2);
        chk("avg_max", capv(2), 131071);
        chk("avg_min", capv(3), -131072);
`endif

        m_ready = 1'b0;
        decim_log2 = 3'd0;
        for (int i = 0; i < 5; i++) send(300 + i);
        decim_log2 = 3'd2;
        send(50);
        send(51);
        chk("prerst_level", int'(level), 5);
        rst_n = 1'b0;
        #2;
        chk("inrst_level", int'(level), 0);
        chk("inrst_valid", int'(m_valid), 0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("postrst_level", int'(level), 0);
        chk("postrst_valid", int'(m_valid), 0);
        chk("postrst_ovf", int'(ovf), 0);
        cap.delete();
        cap_en = 1'b1;
        m_ready = 1'b1;
        for (int i = 7; i <= 10; i++) send(i);
        repeat (4) tick();
        cap_en = 1'b0;
        chk("postrst_count", cap.size(), 1);
        chk("postrst_data", capv(0), RS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
